instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped instruction cache that answers the instruction queue's fetch requests and fills misses from the memory arbiter. Accepts one 17-bit, halfword-aligned fetch address at a time and returns the instruction starting there plus a compressed flag. Handles 32-bit instructions that straddle two cache words. Every accepted request yields exactly one response pulse, including after a pipeline flush; the queue discards stale responses itself.

## Interface
- LINES, 64: number of 4-byte lines, a power of two ≥2. Index is addr[IDX+1:2] with IDX=log2(LINES); tag is addr[16:IDX+2].
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- icache_fetch_en  in  1  fetch request; sampled at posedge only when the block is idle.
- icache_fetch_addr  in  17  byte address of the instruction; bit 0 is always 0.
- icache_out_en  out  1  one-cycle response pulse.
- icache_instruction  out  32  if compressed, {16'b0, halfword}; otherwise the full 32-bit instruction.
- icache_cinstruction  out  1  1 when the halfword at the address has bits[1:0] != 2'b11.
- mem_fetch_en  out  1  word-fill request to the arbiter; level, held until done.
- mem_fetch_addr  out  17  word-aligned fill address (bits[1:0]=0).
- mem_fetch_done  in  1  one-cycle pulse; mem_fetch_data is valid in the same cycle.
- mem_fetch_data  in  32  filled word, little-endian.

## Operation
- Storage per line: valid bit, tag, 32-bit data. Reset clears all valid bits.
- Words for a request at address A:
  - w = A[16:2]; wn = (w+1) mod 2^15, which wraps 0x1FFFC → 0x00000.
  - If A[1]=0: the low halfword of w decides compressed. A 32-bit instruction is word w.
  - If A[1]=1: the high halfword of w decides compressed. A 32-bit instruction is {low16(wn), high16(w)}.
- States:
  - IDLE: accepts a request; a request seen while not IDLE is ignored (protocol violation).
  - LOOKUP: combinational check of w and, if needed, wn.
  - FILL_LO: waits for the fill of w.
  - GAP: one cycle with mem_fetch_en low.
  - FILL_HI: waits for the fill of wn.
  - RESP: drives the response.
- Transitions:
  - From the request edge: w miss → FILL_LO (addr w<<2). Otherwise, straddling non-compressed with wn miss → FILL_HI (addr wn<<2). Otherwise → RESP.
  - FILL_LO on done: write line w, then re-evaluate. Straddle with wn miss → GAP → FILL_HI. Otherwise → RESP.
  - FILL_HI on done: write line wn → RESP.
  - RESP: out_en=1 for one cycle → IDLE. A new request in the RESP cycle is accepted, giving back-to-back operation.
- If w and wn map to the same index (only possible when LINES=1): not supported, since LINES≥2.
- Outputs are registered. instruction and cinstruction hold their values after the pulse until the next response.
- No invalidation; code is not self-modifying.
- Reset mid-fill: all state returns to reset values immediately. A later mem_fetch_done with no request outstanding is ignored.

## Timing
- Reset values: icache_out_en=0, icache_instruction=0, icache_cinstruction=0, mem_fetch_en=0, mem_fetch_addr=0, state IDLE. icache_fetch_en is ignored while rst is high.
- Hit: request sampled at edge T; out_en high in cycle T+1.
- Single miss: mem_fetch_en high from T+1 until the done cycle D; out_en in D+1.
- Double miss: first done D1; GAP in D1+1; second request from D1+2; second done D2; out_en in D2+1.
- Straddle with w hit and wn miss: mem_fetch_en from T+1 (addr wn).
- mem_fetch_en drops in the cycle after done. mem_fetch_addr is stable while en is high.

## Test plan
- Cold miss: fetch 0x00000, arbiter returns 0x00A00093 after 3 cycles. Required: one mem request at addr 0x0, then out_en with instruction 0x00A00093, cinstruction=0.
- Repeat fetch 0x00000 after that fill. Required: out_en exactly 1 cycle after the request, no mem_fetch_en.
- Compressed at A[1]=1: word at 0x4 = 0x4505_0001, fetch 0x00006. Required: instruction 0x00004505, cinstruction=1, single fill of 0x4.
- Straddle, both lines missing: fetch 0x00012, word 0x10 = 0x0093_xxxx, word 0x14 = 0xyyyy_00A0. Required: fills 0x10 then 0x14 with a one-cycle gap, instruction 0x00A00093.
- Wraparound and conflict:
  - Fetch 0x1FFFE (32-bit). Required: second fill address 0x00000.
  - Then fetch 0x00100 with LINES=64. Required: evicts line 0 and triggers a refill.
- Assert rst during FILL_LO. Required: mem_fetch_en=0 and out_en=0 immediately; a stray done is ignored.
- A request issued while busy. Required: it is ignored, and exactly one out_en is produced for the original request.

Source files
------------

// File: rtl/instruction_cache_if.sv
// Fetch-side and fill-side signals of the instruction cache.
// The cache uses the slave view; the queue/arbiter environment uses the master view.
interface instruction_cache_if;
   logic        icache_fetch_en;
   logic [16:0] icache_fetch_addr;
   logic        icache_out_en;
   logic [31:0] icache_instruction;
   logic        icache_cinstruction;
   logic        mem_fetch_en;
   logic [16:0] mem_fetch_addr;
   logic        mem_fetch_done;
   logic [31:0] mem_fetch_data;

   modport master (
      output icache_fetch_en, icache_fetch_addr, mem_fetch_done, mem_fetch_data,
      input  icache_out_en, icache_instruction, icache_cinstruction,
             mem_fetch_en, mem_fetch_addr
   );

   modport slave (
      input  icache_fetch_en, icache_fetch_addr, mem_fetch_done, mem_fetch_data,
      output icache_out_en, icache_instruction, icache_cinstruction,
             mem_fetch_en, mem_fetch_addr
   );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with word fills; returns 16- or 32-bit instructions,
// including 32-bit instructions that straddle two cache words.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a fetch; tag lookup is combinational on the request
// FILL_LO | waiting for the fill of the word holding the address
// GAP     | one cycle with the fill request low between two fills
// FILL_HI | waiting for the fill of the following word (straddle)
// RESP    | response pulse; a new fetch may be accepted in this cycle
module instruction_cache #(
   parameter int LINES = 64
) (
   input  logic                clk,
   input  logic                rst,
   instruction_cache_if.slave  bus
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 15 - IDX;

   typedef enum logic [2:0] {IDLE, FILL_LO, GAP, FILL_HI, RESP} state_t;

   state_t      state, state_n;
   logic [16:1] req, req_n, lk;
   logic        out_en, out_en_n;
   logic [31:0] instr, instr_n;
   logic        cinstr, cinstr_n;
   logic        mem_en, mem_en_n;
   logic [16:0] mem_addr, mem_addr_n;

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tags [LINES];
   logic [31:0]      data [LINES];

   logic [14:0]     w, wn;
   logic [IDX-1:0]  w_idx, wn_idx, wr_idx;
   logic [TW-1:0]   w_tag, wn_tag, wr_tag;
   logic            a1, hit_w, hit_wn, wr_en;
   logic [31:0]     word_w, word_wn;

   function automatic logic needs_hi(input logic hi_half, input logic [31:0] lo);
      logic [15:0] hw;
      hw = hi_half ? lo[31:16] : lo[15:0];
      return hi_half && (hw[1:0] == 2'b11);
   endfunction

   // {compressed, instruction}
   function automatic logic [32:0] build(input logic hi_half, input logic [31:0] lo,
                                         input logic [31:0] hi);
      logic [15:0] hw;
      hw = hi_half ? lo[31:16] : lo[15:0];
      if (hw[1:0] != 2'b11) return {1'b1, 16'h0000, hw};
      else if (hi_half)     return {1'b0, hi[15:0], lo[31:16]};
      else                  return {1'b0, lo};
   endfunction

   // While accepting, look up the incoming address; otherwise the held request.
   assign lk      = (state == IDLE || state == RESP) ? bus.icache_fetch_addr[16:1] : req;
   assign a1      = lk[1];
   assign w       = lk[16:2];
   assign wn      = w + 15'd1;
   assign w_idx   = w[IDX-1:0];
   assign wn_idx  = wn[IDX-1:0];
   assign w_tag   = w[14:IDX];
   assign wn_tag  = wn[14:IDX];
   assign word_w  = data[w_idx];
   assign word_wn = data[wn_idx];
   assign hit_w   = valid[w_idx]  && (tags[w_idx]  == w_tag);
   assign hit_wn  = valid[wn_idx] && (tags[wn_idx] == wn_tag);

   always_comb begin
      state_n    = state;
      req_n      = req;
      out_en_n   = 1'b0;
      instr_n    = instr;
      cinstr_n   = cinstr;
      mem_en_n   = mem_en;
      mem_addr_n = mem_addr;
      wr_en      = 1'b0;
      wr_idx     = w_idx;
      wr_tag     = w_tag;
      case (state)
         IDLE, RESP: begin
            state_n = IDLE;
            if (bus.icache_fetch_en) begin
               req_n = lk;
               if (!hit_w) begin
                  state_n    = FILL_LO;
                  mem_en_n   = 1'b1;
                  mem_addr_n = {w, 2'b00};
               end else if (needs_hi(a1, word_w) && !hit_wn) begin
                  state_n    = FILL_HI;
                  mem_en_n   = 1'b1;
                  mem_addr_n = {wn, 2'b00};
               end else begin
                  state_n               = RESP;
                  out_en_n              = 1'b1;
                  {cinstr_n, instr_n}   = build(a1, word_w, word_wn);
               end
            end
         end
         FILL_LO: begin
            if (bus.mem_fetch_done) begin
               wr_en    = 1'b1;
               mem_en_n = 1'b0;
               if (needs_hi(a1, bus.mem_fetch_data) && !hit_wn) begin
                  state_n = GAP;
               end else begin
                  state_n             = RESP;
                  out_en_n            = 1'b1;
                  {cinstr_n, instr_n} = build(a1, bus.mem_fetch_data, word_wn);
               end
            end
         end
         GAP: begin
            state_n    = FILL_HI;
            mem_en_n   = 1'b1;
            mem_addr_n = {wn, 2'b00};
         end
         FILL_HI: begin
            if (bus.mem_fetch_done) begin
               wr_en               = 1'b1;
               wr_idx              = wn_idx;
               wr_tag              = wn_tag;
               mem_en_n            = 1'b0;
               state_n             = RESP;
               out_en_n            = 1'b1;
               {cinstr_n, instr_n} = build(a1, word_w, bus.mem_fetch_data);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req      <= '0;
         out_en   <= 1'b0;
         instr    <= '0;
         cinstr   <= 1'b0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
      end else begin
         state    <= state_n;
         req      <= req_n;
         out_en   <= out_en_n;
         instr    <= instr_n;
         cinstr   <= cinstr_n;
         mem_en   <= mem_en_n;
         mem_addr <= mem_addr_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        valid         <= '0;
      else if (wr_en) valid[wr_idx] <= 1'b1;
   end

   // Tag and data storage carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= bus.mem_fetch_data;
      end
   end

   assign bus.icache_out_en       = out_en;
   assign bus.icache_instruction  = instr;
   assign bus.icache_cinstruction = cinstr;
   assign bus.mem_fetch_en        = mem_en;
   assign bus.mem_fetch_addr      = mem_addr;
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios then random fetches, checked against
// a word-level memory image and a line-occupancy model of a 64-line direct-mapped cache.
module tb_instruction_cache;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instruction_cache_if bus ();
   instruction_cache #(.LINES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] mem    [0:32767];
   logic [14:0] mline  [0:63];
   logic        mvalid [0:63];
   logic [14:0] exp_fills [$];
   logic [31:0] exp_i;
   logic        exp_c;
   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic mhit(input logic [14:0] wd);
      int i;
      i = int'(wd) % 64;
      return mvalid[i] && (mline[i] == wd);
   endfunction

   task automatic install(input logic [14:0] wd);
      int i;
      i = int'(wd) % 64;
      mvalid[i] = 1'b1;
      mline[i]  = wd;
   endtask

   task automatic predict(input logic [16:0] a);
      logic [14:0] w, wn;
      logic [15:0] hw;
      w  = a[16:2];
      wn = w + 15'd1;
      exp_fills.delete();
      if (!mhit(w)) begin
         exp_fills.push_back(w);
         install(w);
      end
      hw    = a[1] ? mem[w][31:16] : mem[w][15:0];
      exp_c = (hw[1:0] != 2'b11);
      if (a[1] && !exp_c && !mhit(wn)) begin
         exp_fills.push_back(wn);
         install(wn);
      end
      if (exp_c)     exp_i = {16'h0000, hw};
      else if (a[1]) exp_i = {mem[wn][15:0], hw};
      else           exp_i = mem[w];
   endtask

   task automatic do_fetch(input logic [16:0] a, input bit poke);
      int k, nf, wait_cnt, extra;
      bit active, done_prev, was_done, got;
      logic [16:0] faddr;
      predict(a);
      @(negedge clk);
      bus.icache_fetch_en   = 1'b1;
      bus.icache_fetch_addr = a;
      @(negedge clk);
      bus.icache_fetch_en = 1'b0;
      k = 1; nf = 0; wait_cnt = 0; active = 0; done_prev = 0; got = 0; faddr = '0;
      if (poke && exp_fills.size() > 0) begin
         bus.icache_fetch_en   = 1'b1;
         bus.icache_fetch_addr = a ^ 17'h00104;
      end
      while (!got && k < 200) begin
         if (k == 2) bus.icache_fetch_en = 1'b0;
         bus.mem_fetch_done = 1'b0;
         was_done  = done_prev;
         done_prev = 0;
         if (was_done) begin
            chk("fill_en_drop", 32'(bus.mem_fetch_en), 32'd0);
         end else if (!active && bus.mem_fetch_en) begin
            chk("fill_expected", 32'(nf < exp_fills.size()), 32'd1);
            if (nf < exp_fills.size())
               chk("fill_addr", 32'(bus.mem_fetch_addr), 32'({exp_fills[nf], 2'b00}));
            faddr    = bus.mem_fetch_addr;
            active   = 1;
            wait_cnt = $urandom_range(0, 3);
            nf++;
         end
         if (active) begin
            if (bus.mem_fetch_en !== 1'b1 || bus.mem_fetch_addr !== faddr)
               chk("fill_req_stable", {15'd0, bus.mem_fetch_en, bus.mem_fetch_addr},
                   {15'd0, 1'b1, faddr});
            if (wait_cnt == 0) begin
               bus.mem_fetch_done = 1'b1;
               bus.mem_fetch_data = mem[faddr[16:2]];
               active    = 0;
               done_prev = 1;
            end else begin
               wait_cnt--;
            end
         end
         if (bus.icache_out_en) begin
            got = 1;
            chk("resp_fill_count", 32'(nf), 32'(exp_fills.size()));
            if (exp_fills.size() == 0) chk("hit_latency", 32'(k), 32'd1);
            else                       chk("miss_latency", 32'(was_done), 32'd1);
            chk("instruction", bus.icache_instruction, exp_i);
            chk("cinstruction", 32'(bus.icache_cinstruction), 32'(exp_c));
         end
         if (!got) begin
            @(negedge clk);
            k++;
         end
      end
      if (!got) chk("resp_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.mem_fetch_done = 1'b0;
      chk("pulse_width", 32'(bus.icache_out_en), 32'd0);
      chk("instr_hold", bus.icache_instruction, exp_i);
      if (poke) begin
         extra = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.icache_out_en) extra++;
         end
         chk("busy_extra_resp", 32'(extra), 32'd0);
      end
   endtask

   initial begin
      logic [16:0] base, a;
      int quiet;
      rst = 1'b1;
      bus.icache_fetch_en   = 1'b0;
      bus.icache_fetch_addr = '0;
      bus.mem_fetch_done    = 1'b0;
      bus.mem_fetch_data    = '0;
      for (int i = 0; i < 32768; i++) mem[i] = $urandom;
      for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mline[i] = '0; end
      mem[0]       = 32'h00A00093;
      mem[1]       = 32'h45050001;
      mem[4]       = 32'h00931234;
      mem[5]       = 32'h567800A0;
      mem[15'h7FFF] = 32'h00130000;

      repeat (3) @(negedge clk);
      chk("rst_out_en", 32'(bus.icache_out_en), 32'd0);
      chk("rst_instr", bus.icache_instruction, 32'd0);
      chk("rst_cinstr", 32'(bus.icache_cinstruction), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_fetch_en), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_fetch_addr), 32'd0);
      rst = 1'b0;

      do_fetch(17'h00000, 0);   // cold miss
      do_fetch(17'h00000, 0);   // hit
      do_fetch(17'h00006, 0);   // compressed in high half
      do_fetch(17'h00012, 0);   // straddle, both words missing
      do_fetch(17'h00100, 0);   // evicts line 0
      do_fetch(17'h1FFFE, 0);   // straddle wrapping to word 0
      do_fetch(17'h00100, 0);   // evicts line 0 again
      do_fetch(17'h00C08, 1);   // request while busy is ignored

      // Reset in the middle of a fill
      @(negedge clk);
      bus.icache_fetch_en   = 1'b1;
      bus.icache_fetch_addr = 17'h00A04;
      @(negedge clk);
      bus.icache_fetch_en = 1'b0;
      chk("prerst_fill_en", 32'(bus.mem_fetch_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_mem_en", 32'(bus.mem_fetch_en), 32'd0);
      chk("midrst_out_en", 32'(bus.icache_out_en), 32'd0);
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.mem_fetch_done = 1'b1;
      bus.mem_fetch_data = 32'hDEADBEEF;
      @(negedge clk);
      bus.mem_fetch_done = 1'b0;
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.icache_out_en || bus.mem_fetch_en) quiet++;
         @(negedge clk);
      end
      chk("stray_done_ignored", 32'(quiet), 32'd0);
      do_fetch(17'h00000, 0);   // cache was emptied by reset

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 2))
            0:       base = 17'h00000;
            1:       base = 17'h00100;
            default: base = 17'h1FF00;
         endcase
         a = base + 17'($urandom_range(0, 127) * 2);
         do_fetch(a, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
